// File: rtl/c2f_chunk_consumer_if.sv
// Bus bundle between the C2F chunk consumer and its burst-write RAM / producer.
// A chunk at rdPtr is available while wrPtr != rdPtr; the consumer releases it with a
// one-cycle dtAck, and rdPtr advances on the following cycle. There is no backpressure.
interface c2f_chunk_consumer_if #(
  parameter int DATA_WIDTH  = 64,
  parameter int CHUNK_WORDS = 16,
  parameter int PTR_BITS    = 3
);
  localparam int OFF_BITS = $clog2(CHUNK_WORDS);

  logic [PTR_BITS-1:0]   wrPtr;
  logic [PTR_BITS-1:0]   rdPtr;
  logic                  dtAck;
  logic [OFF_BITS-1:0]   rdOffset;
  logic [DATA_WIDTH-1:0] rdData;
  logic [DATA_WIDTH-1:0] csData;
  logic                  csValid;
  logic                  csReset;
  logic [31:0]           countInit;

  modport master (
    input  wrPtr, rdData, csReset, countInit,
    output rdPtr, dtAck, rdOffset, csData, csValid
  );

  modport slave (
    output wrPtr, rdData, csReset, countInit,
    input  rdPtr, dtAck, rdOffset, csData, csValid
  );
endinterface

// File: rtl/c2f_chunk_consumer.sv
// Drains chunks from the C2F burst-write RAM, acks each one, and folds returned
// words into a run-time-bounded checksum (sum or XOR).
module c2f_chunk_consumer #(
  parameter int DATA_WIDTH  = 64,
  parameter int CHUNK_WORDS = 16,
  parameter int PTR_BITS    = 3,
  parameter int RD_LATENCY  = 1,
  parameter int CS_MODE     = 0
) (
  input  logic                     sysClk,
  input  logic                     sysRst_n,
  c2f_chunk_consumer_if.master     bus,
  output logic [1:0]               dbg_state
);
  localparam int OFF_BITS = $clog2(CHUNK_WORDS);
  localparam int LAT_BITS = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [OFF_BITS-1:0] LAST_OFF   = OFF_BITS'(CHUNK_WORDS - 1);
  localparam logic [LAT_BITS-1:0] LAST_DRAIN = LAT_BITS'(RD_LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_ACK   = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [PTR_BITS-1:0]   rd_ptr_q, rd_ptr_d;
  logic [OFF_BITS-1:0]   rd_off_q, rd_off_d;
  logic                  dt_ack_q, dt_ack_d;
  logic [LAT_BITS-1:0]   drain_cnt_q, drain_cnt_d;
  logic [RD_LATENCY-1:0] issue_pipe_q, issue_pipe_d;
  logic                  issue;
  logic                  returned;

  logic [DATA_WIDTH-1:0] cs_q, cs_d;
  logic                  cs_valid_q, cs_valid_d;
  logic [31:0]           remaining_q, remaining_d;
  logic                  load_pending_q, load_pending_d;

  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    rd_off_d    = rd_off_q;
    drain_cnt_d = drain_cnt_q;
    dt_ack_d    = 1'b0;
    issue       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.wrPtr != rd_ptr_q) begin
          state_d  = ST_READ;
          rd_off_d = '0;
        end
      end
      ST_READ: begin
        issue = 1'b1;
        if (rd_off_q == LAST_OFF) begin
          state_d     = ST_DRAIN;
          rd_off_d    = '0;
          drain_cnt_d = '0;
        end else begin
          rd_off_d = rd_off_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        // The last word comes back during the final drain cycle.
        if (drain_cnt_q == LAST_DRAIN) begin
          state_d  = ST_ACK;
          dt_ack_d = 1'b1;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end
      ST_ACK: begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign issue_pipe_d = RD_LATENCY'({issue_pipe_q, issue});
  assign returned     = issue_pipe_q[RD_LATENCY-1];

  // A load (reset-pending or csReset) wins over a word returning in the same cycle.
  always_comb begin
    cs_d           = cs_q;
    cs_valid_d     = cs_valid_q;
    remaining_d    = remaining_q;
    load_pending_d = load_pending_q;
    if (load_pending_q || bus.csReset) begin
      cs_d           = '0;
      remaining_d    = bus.countInit;
      cs_valid_d     = (bus.countInit == 32'd0);
      load_pending_d = 1'b0;
    end else if (returned && (remaining_q != 32'd0)) begin
      cs_d        = (CS_MODE == 1) ? (cs_q ^ bus.rdData) : (cs_q + bus.rdData);
      remaining_d = remaining_q - 32'd1;
      if (remaining_q == 32'd1) begin
        cs_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge sysClk or negedge sysRst_n) begin
    if (!sysRst_n) begin
      state_q        <= ST_IDLE;
      rd_ptr_q       <= '0;
      rd_off_q       <= '0;
      dt_ack_q       <= 1'b0;
      drain_cnt_q    <= '0;
      issue_pipe_q   <= '0;
      cs_q           <= '0;
      cs_valid_q     <= 1'b0;
      remaining_q    <= '0;
      load_pending_q <= 1'b1;
    end else begin
      state_q        <= state_d;
      rd_ptr_q       <= rd_ptr_d;
      rd_off_q       <= rd_off_d;
      dt_ack_q       <= dt_ack_d;
      drain_cnt_q    <= drain_cnt_d;
      issue_pipe_q   <= issue_pipe_d;
      cs_q           <= cs_d;
      cs_valid_q     <= cs_valid_d;
      remaining_q    <= remaining_d;
      load_pending_q <= load_pending_d;
    end
  end

  assign bus.rdPtr    = rd_ptr_q;
  assign bus.rdOffset = rd_off_q;
  assign bus.dtAck    = dt_ack_q;
  assign bus.csData   = cs_q;
  assign bus.csValid  = cs_valid_q;
  assign dbg_state    = state_q;
endmodule

// File: doc/c2f_chunk_consumer.md
Name: c2f_chunk_consumer

Overview:
- Parametrised successor to the single-purpose CPU->FPGA chunk consumer.
- Drains chunks from the C2F burst-write RAM (`{rdPtr, rdOffset}` addressing) whenever the producer's `wrPtr` is ahead of its own `rdPtr`.
- Acknowledges each completed chunk with a one-cycle `dtAck` and advances `rdPtr`.
- Folds returned words into a run-time-bounded checksum (SUM or XOR mode).
- Generalised over data width, chunk depth, ring size and RAM read latency.

Parameters:
- DATA_WIDTH, 64, RAM word width in bits; also the checksum width.
- CHUNK_WORDS, 16, words per chunk; must be a power of two, >=2.
- PTR_BITS, 3, chunk-pointer width; the ring holds 2^PTR_BITS chunks.
- RD_LATENCY, 1, cycles from `rdOffset`/`rdPtr` change to valid `rdData`; range 1..4.
- CS_MODE, 0, checksum operator: 0 = sum modulo 2^DATA_WIDTH, 1 = bitwise XOR.

Ports:
- sysClk  in  1  system clock; all logic on the rising edge.
- sysRst_n  in  1  asynchronous, active-low reset.
- wrPtr  in  PTR_BITS  producer chunk pointer (next chunk to be written).
- rdPtr  out  PTR_BITS  consumer chunk pointer (chunk being or next to be read).
- dtAck  out  1  one-cycle pulse when the chunk at `rdPtr` is fully consumed.
- rdOffset  out  log2(CHUNK_WORDS)  word offset within the chunk, driven to the RAM.
- rdData  in  DATA_WIDTH  RAM read data.
- csData  out  DATA_WIDTH  checksum accumulator.
- csValid  out  1  high once `countInit` words have been accumulated.
- csReset  in  1  synchronous checksum restart.
- countInit  in  32  number of words to accumulate per checksum run.

Behaviour:
- Asynchronous reset (`sysRst_n` = 0):
  - `rdPtr`=0, `rdOffset`=0, `dtAck`=0, `csData`=0, `csValid`=0.
  - FSM goes to IDLE, read-valid pipeline cleared, internal `remaining`=0, `loadPending`=1.
  - Reset asserted mid-chunk abandons the chunk; no `dtAck` is issued for it.
- FSM states and transitions:
  - IDLE: if `wrPtr` != `rdPtr`, go to READ with `rdOffset`=0; otherwise stay.
  - READ: `rdOffset` increments by one each cycle; `issue`=1 every READ cycle. After the cycle presenting offset CHUNK_WORDS-1, go to DRAIN and hold `rdOffset` at 0.
  - DRAIN: wait RD_LATENCY cycles until the last word returns, then go to ACK.
  - ACK: `dtAck`=1 for exactly one cycle; `rdPtr` <= `rdPtr`+1 modulo 2^PTR_BITS, wrapping 2^PTR_BITS-1 -> 0. Go to IDLE.
- Chunk timing:
  - With `wrPtr` already ahead of `rdPtr`, a chunk occupies 1 (IDLE) + CHUNK_WORDS + RD_LATENCY + 1 cycles.
  - Back-to-back chunks always pass through IDLE for one cycle.
- Empty and full:
  - Ring is empty when `wrPtr` == `rdPtr`.
  - The producer keeps at most 2^PTR_BITS-1 chunks outstanding; otherwise a full ring reads as empty. This block does not detect that condition.
- `wrPtr` is sampled only in IDLE. Changes during READ/DRAIN/ACK do not disturb the current chunk.
- Read-valid tracking: a RD_LATENCY-deep shift register of `issue`. A word is "returned" when the delayed `issue` bit is 1, and `rdData` is sampled that cycle.
- Checksum load:
  - Occurs on any clock where `loadPending`=1 or `csReset`=1.
  - Load sets `csData`=0, `remaining`=`countInit`, `csValid`=(`countInit`==0), `loadPending`=0.
  - Load takes priority over a coincident returned word; that word is discarded from the checksum.
- Checksum accumulate: on a returned word with no load and `remaining` > 0:
  - `csData` <= `csData`+`rdData` (CS_MODE 0) or `csData` ^ `rdData` (CS_MODE 1).
  - `remaining` decrements.
  - `csValid` <= 1 when `remaining` goes 1 -> 0.
- Checksum hold: with `remaining`==0, returned words are ignored. `csData` and `csValid` hold until the next load.
- The checksum spans chunk boundaries freely; it is independent of `dtAck`.

Test Plan:
(All scenarios use default parameters unless stated.)
- Reset: hold `sysRst_n`=0 with `wrPtr`=5 -> `rdPtr`=0, `dtAck`=0, `csValid`=0, `csData`=0, `rdOffset`=0; no RAM reads.
- Single chunk: RAM chunk 0 holds 1..16, `countInit`=16, `wrPtr` 0->1 -> `rdOffset` 0..15 on consecutive cycles; `dtAck` pulses once, 19 cycles after `wrPtr` is seen; `rdPtr`=1; `csData`=136; `csValid`=1.
- Wrap: write 7 chunks, consume, then 3 more -> exactly 10 `dtAck` pulses; `rdPtr` sequence 0..7, 0, 1, 2 ending at 2; no reads while `wrPtr`==`rdPtr`.
- Cross-chunk count: `countInit`=20, chunks hold 1..32 -> `csValid` rises the cycle after word 20 returns; `csData`=210; words 21..32 leave `csData`=210.
- csReset collision: assert `csReset` the same cycle word 5 returns, `countInit`=4 -> word 5 is dropped; `csData`=6+7+8+9=30; `csValid`=1 after word 9.
- Mid-chunk reset plus XOR mode: CS_MODE=1, RD_LATENCY=3, drop `sysRst_n` at `rdOffset`=7 -> outputs zero immediately, no `dtAck`. After release, chunk 0 is re-read from offset 0. `csData` is the XOR of 16 words, checked against the model.
